fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage feeding the fetch/decode boundary of the pipeline. Holds the fetch PC and issues one outstanding instruction-memory request at a time. Recovers from branch/jump redirects by dropping in-flight responses, and presents a registered `{valid, instr, pc, pc_plus4}` bundle to the decode stage with stall, flush and a one-entry holding buffer.

## Interface
- `ADDR_WIDTH`, 64: PC and memory address width.
- `INSTR_WIDTH`, 32: instruction word width.
- `RESET_VECTOR`, 0: first fetch address after reset.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_srst`  in  1  reset; synchronous, active-high.
- `i_stall_dec`  in  1  decode stall; hold the output register.
- `i_flush_dec`  in  1  squash the output register (bubble).
- `i_redirect`  in  1  control-flow redirect from execute.
- `i_redirect_pc`  in  ADDR_WIDTH  redirect target.
- `o_req_valid`  out  1  memory request valid.
- `o_req_addr`  out  ADDR_WIDTH  request address (= fetch PC).
- `i_req_ready`  in  1  memory accepts the request this cycle.
- `i_rsp_valid`  in  1  response valid.
- `i_rsp_instr`  in  INSTR_WIDTH  response instruction.
- `o_valid`  out  1  decode bundle valid.
- `o_instr`  out  INSTR_WIDTH  instruction; NOP `32'h0000_0013` when invalid.
- `o_pc`  out  ADDR_WIDTH  PC of `o_instr`.
- `o_pc_plus4`  out  ADDR_WIDTH  `o_pc + 4`.

## Operation
- State registers:
  - `fetch_pc`.
  - FSM state: S_REQ, S_WAIT, S_DROP.
  - Holding buffer `{buf_valid, buf_instr, buf_pc}`.
  - Output register.
- `o_req_valid = !i_srst && state==S_REQ && !buf_valid`; `o_req_addr = fetch_pc`.
- S_REQ:
  - Handshake (`o_req_valid && i_req_ready`) without redirect: `fetch_pc += 4`, latch the issued PC as `req_pc`, go to S_WAIT.
  - Handshake with redirect: `fetch_pc <= redirect target`, go to S_DROP.
  - Redirect without handshake: `fetch_pc <= redirect target`, stay in S_REQ.
  - `i_rsp_valid` is ignored in this state.
- S_WAIT:
  - `i_rsp_valid` without redirect: deliver `{i_rsp_instr, req_pc}` and go to S_REQ.
    - If `!i_stall_dec && !i_flush_dec`, it loads the output register.
    - Else if `i_stall_dec && !i_flush_dec`, it loads the buffer.
    - If `i_flush_dec`, it is discarded.
  - `i_rsp_valid` with redirect: drop the response, `fetch_pc <= target`, go to S_REQ.
  - Redirect without response: `fetch_pc <= target`, go to S_DROP.
- S_DROP:
  - `i_rsp_valid`: discard the response, go to S_REQ.
  - Redirect: update `fetch_pc`, stay in S_DROP.
- Redirect target is `{i_redirect_pc[ADDR_WIDTH-1:2], 2'b00}`.
- Redirect clears `buf_valid`. It does not touch the output register; the controller pairs it with `i_flush_dec`.
- Output register update, in priority order:
  1. `i_srst`: reset values.
  2. `i_flush_dec`: bubble (`o_valid=0`, NOP, pc and pc_plus4 = 0).
  3. `i_stall_dec`: hold.
  4. `buf_valid`: load from the buffer, clear `buf_valid`.
  5. Response delivered this cycle: load it.
  6. Otherwise: bubble.
- `i_flush_dec` also clears `buf_valid`.
- Arithmetic: `fetch_pc + 4` and `o_pc + 4` wrap modulo 2^ADDR_WIDTH. An address of `{ADDR_WIDTH{1'b1}} & ~3` wraps to 0.
- Buffer cannot overflow: requests issue only while the buffer is empty, and at most one request is outstanding.

## Timing
- Reset values:
  - State S_REQ, `fetch_pc = RESET_VECTOR`, `buf_valid = 0`.
  - `o_valid=0`, `o_instr=32'h0000_0013`, `o_pc=0`, `o_pc_plus4=0`.
  - `o_req_valid=0` while `i_srst` is high.
- First request: `o_req_valid=1` with `o_req_addr=RESET_VECTOR` in the first cycle after `i_srst` drops.
- Latency: response accepted in cycle t → `o_valid=1` in cycle t+1 (no stall).
- Throughput: at most one instruction per 2 cycles (request cycle, response cycle).
- Redirect in cycle t → request to the target in cycle t+1 from S_REQ, or after the dropped response from S_DROP.
- Redirect coincident with a response: the redirect wins and the response is never delivered.
- Reset mid-transaction: state returns to S_REQ; a late response is ignored there. The memory is reset by the same `i_srst`.
- Stall/flush coincident: flush wins.

## Test plan
- Reset with `RESET_VECTOR=0x1000`, memory ready with 1-cycle response → requests at 0x1000, 0x1004, 0x1008; `o_valid` every 2nd cycle; `o_pc_plus4 = o_pc + 4`.
- Response arrives while `i_stall_dec=1` for 3 cycles → output holds the old bundle; the buffered instr appears the cycle after stall drops; no new request issued while the buffer is full.
- Redirect to 0x2002 one cycle after a request is accepted → that response is dropped; next `o_req_addr=0x2000`; the first valid output has `o_pc=0x2000`.
- Redirect in the same cycle as `i_rsp_valid` → response not delivered; next request at the target.
- `i_flush_dec` and `i_stall_dec` together with a full buffer → `o_valid=0`, NOP output, buffer cleared.
- `fetch_pc=0xFFFF_FFFF_FFFF_FFFC` → `o_pc_plus4=0`; next request address 0. Asserting `i_srst` during S_WAIT → `o_req_valid=0`, then a request at `RESET_VECTOR`.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// fetch_stage: single-outstanding instruction fetch with redirect drop handling,
// a one-entry holding buffer and a registered decode bundle.
module fetch_stage #(
    parameter int                    ADDR_WIDTH   = 64,
    parameter int                    INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   i_clk,
    input  logic                   i_srst,
    input  logic                   i_stall_dec,
    input  logic                   i_flush_dec,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_req_valid,
    output logic [ADDR_WIDTH-1:0]  o_req_addr,
    input  logic                   i_req_ready,
    input  logic                   i_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] i_rsp_instr,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4
);

    localparam logic [INSTR_WIDTH-1:0] NOP  = INSTR_WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0]  FOUR = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                   state, state_next;
    logic [ADDR_WIDTH-1:0]    fetch_pc, fetch_pc_next, req_pc, redirect_target;
    logic                     buf_valid;
    logic [INSTR_WIDTH-1:0]   buf_instr;
    logic [ADDR_WIDTH-1:0]    buf_pc;
    logic                     req_fire, rsp_deliver;
    logic                     unused_redirect_lsbs;

    assign redirect_target      = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    assign o_req_valid = !i_srst && (state == S_REQ) && !buf_valid;
    assign o_req_addr  = fetch_pc;
    assign req_fire    = o_req_valid && i_req_ready;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        rsp_deliver   = 1'b0;
        case (state)
            S_REQ: begin
                if (req_fire) state_next = i_redirect ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (i_rsp_valid) begin
                    state_next  = S_REQ;
                    rsp_deliver = !i_redirect;
                end else if (i_redirect) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (i_rsp_valid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
        if (i_redirect)    fetch_pc_next = redirect_target;
        else if (req_fire) fetch_pc_next = fetch_pc + FOUR;
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state      <= S_REQ;
            fetch_pc   <= RESET_VECTOR;
            req_pc     <= '0;
            buf_valid  <= 1'b0;
            buf_instr  <= NOP;
            buf_pc     <= '0;
            o_valid    <= 1'b0;
            o_instr    <= NOP;
            o_pc       <= '0;
            o_pc_plus4 <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if (req_fire && !i_redirect) req_pc <= fetch_pc;

            // Buffer fills only when a response arrives under stall; it drains
            // into the output register the first unstalled cycle.
            if (i_redirect || i_flush_dec) begin
                buf_valid <= 1'b0;
            end else if (buf_valid && !i_stall_dec) begin
                buf_valid <= 1'b0;
            end else if (rsp_deliver && i_stall_dec) begin
                buf_valid <= 1'b1;
                buf_instr <= i_rsp_instr;
                buf_pc    <= req_pc;
            end

            if (i_flush_dec) begin
                o_valid    <= 1'b0;
                o_instr    <= NOP;
                o_pc       <= '0;
                o_pc_plus4 <= '0;
            end else if (!i_stall_dec) begin
                if (buf_valid) begin
                    o_valid    <= 1'b1;
                    o_instr    <= buf_instr;
                    o_pc       <= buf_pc;
                    o_pc_plus4 <= buf_pc + FOUR;
                end else if (rsp_deliver) begin
                    o_valid    <= 1'b1;
                    o_instr    <= i_rsp_instr;
                    o_pc       <= req_pc;
                    o_pc_plus4 <= req_pc + FOUR;
                end else begin
                    o_valid    <= 1'b0;
                    o_instr    <= NOP;
                    o_pc       <= '0;
                    o_pc_plus4 <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage: randomized fetch/decode traffic against a transaction-level
// reference model of the fetch stage and a variable-latency memory.
module tb_fetch_stage;

    localparam int          AW = 64;
    localparam int          IW = 32;
    localparam logic [63:0] RV = 64'h1000;

    logic          clk = 1'b0;
    logic          srst, stall, flush, redirect, ready, rsp_valid;
    logic [AW-1:0] redirect_pc, req_addr, o_pc, o_pc_plus4;
    logic [IW-1:0] rsp_instr, o_instr;
    logic          req_valid, o_valid;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_VECTOR(RV)) dut (
        .i_clk(clk), .i_srst(srst), .i_stall_dec(stall), .i_flush_dec(flush),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_req_valid(req_valid), .o_req_addr(req_addr), .i_req_ready(ready),
        .i_rsp_valid(rsp_valid), .i_rsp_instr(rsp_instr),
        .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: one pending transaction with a "stale" mark, a
    // one-slot buffer and the decode bundle.
    logic [63:0] m_pc, m_req_pc, m_buf_pc, m_opc, m_opc4;
    logic [31:0] m_buf_i, m_oi;
    bit          m_out, m_stale, m_bv, m_ov, m_req;
    bit          mem_busy;
    int          mem_cnt;
    logic [63:0] mem_addr;

    task automatic model_reset();
        m_pc = RV; m_req_pc = '0; m_out = 0; m_stale = 0; m_bv = 0;
        m_buf_pc = '0; m_buf_i = 32'h13;
        m_ov = 0; m_oi = 32'h13; m_opc = '0; m_opc4 = '0;
        mem_busy = 0; mem_cnt = 0; mem_addr = '0;
    endtask

    initial begin
        bit          fire_env, fire, rsp, deliver, old_bv;
        logic [63:0] tgt;
        srst = 1; stall = 0; flush = 0; redirect = 0; redirect_pc = '0;
        ready = 0; rsp_valid = 0; rsp_instr = '0;
        model_reset();
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            srst     = (cyc > 0) && ($urandom_range(0, 249) == 0);
            stall    = ($urandom_range(0, 99) < 30);
            flush    = ($urandom_range(0, 99) < 8);
            redirect = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 64'h2002;
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
                default: redirect_pc = {$urandom, $urandom};
            endcase
            ready = ($urandom_range(0, 99) < 70);
            if (mem_busy && mem_cnt == 0) begin
                rsp_valid = 1;
                rsp_instr = mem_word(mem_addr);
            end else begin
                rsp_valid = !mem_busy && ($urandom_range(0, 99) < 3);
                rsp_instr = $urandom;
            end
            if (cyc == 0) begin
                stall = 0; flush = 0; redirect = 0; ready = 1;
            end
            #1;
            m_req = !srst && !m_out && !m_bv;
            if (cyc == 0) begin
                check("first_req_valid", {63'd0, req_valid}, 64'd1);
                check("first_req_addr", req_addr, RV);
            end
            check("req_valid", {63'd0, req_valid}, {63'd0, m_req});
            if (m_req) check("req_addr", req_addr, m_pc);
            check("o_valid", {63'd0, o_valid}, {63'd0, m_ov});
            check("o_instr", {32'd0, o_instr}, {32'd0, m_oi});
            check("o_pc", o_pc, m_opc);
            check("o_pc_plus4", o_pc_plus4, m_opc4);

            fire_env = req_valid && ready;
            if (srst) begin
                model_reset();
            end else begin
                fire    = m_req && ready;
                rsp     = rsp_valid && m_out;
                deliver = rsp && !m_stale && !redirect;
                tgt     = {redirect_pc[63:2], 2'b00};
                old_bv  = m_bv;

                if (flush) begin
                    m_ov = 0; m_oi = 32'h13; m_opc = '0; m_opc4 = '0;
                end else if (!stall) begin
                    if (old_bv) begin
                        m_ov = 1; m_oi = m_buf_i; m_opc = m_buf_pc; m_opc4 = m_buf_pc + 64'd4;
                    end else if (deliver) begin
                        m_ov = 1; m_oi = rsp_instr; m_opc = m_req_pc; m_opc4 = m_req_pc + 64'd4;
                    end else begin
                        m_ov = 0; m_oi = 32'h13; m_opc = '0; m_opc4 = '0;
                    end
                end

                if (redirect || flush)      m_bv = 0;
                else if (old_bv && !stall)  m_bv = 0;
                else if (deliver && stall) begin
                    m_bv = 1; m_buf_i = rsp_instr; m_buf_pc = m_req_pc;
                end

                if (m_out) begin
                    if (rsp)           m_out = 0;
                    else if (redirect) m_stale = 1;
                end else if (fire) begin
                    m_out = 1; m_stale = redirect; m_req_pc = m_pc;
                end

                if (redirect)  m_pc = tgt;
                else if (fire) m_pc = m_pc + 64'd4;

                if (rsp_valid && mem_busy) mem_busy = 0;
                else if (mem_busy)         mem_cnt--;
                if (fire_env) begin
                    mem_busy = 1;
                    mem_cnt  = $urandom_range(0, 2);
                    mem_addr = req_addr;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
